// File: rtl/spi_accel_slave.sv
// spi_accel_slave: SPI mode-0 responder for the ADXL362 register protocol (0x0A write, 0x0B read).
// Optional feature macro: SPI_ACCEL_INT_EN drives int1_o/int2_o from DATA_READY; else tied low.
module spi_accel_slave #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_i,
  input  logic        ncs_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe,
  input  logic        sample_valid,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  output logic        busy,
  output logic        int1_o,
  output logic        int2_o
);
  localparam logic [7:0] CmdWrite = 8'h0A;
  localparam logic [7:0] CmdRead  = 8'h0B;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;

  // Synchronizers track the pins even during reset so a held-low nCS is not seen as a new fall.
  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, mosi_sync;
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
    ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_i};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
  end

  logic sclk_rise, sclk_fall, ncs_fall, ncs_rise, mosi_bit, xfer_end;
  assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
  assign ncs_fall  = ~ncs_sync[SYNC_STAGES-2] & ncs_sync[SYNC_STAGES-1];
  assign ncs_rise  = ncs_sync[SYNC_STAGES-2] & ~ncs_sync[SYNC_STAGES-1];
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          rx_q, rx_d;
  logic                byte_vld_q, byte_vld_d;
  logic [7:0]          byte_q, byte_d;
  logic                is_read_q, is_read_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                busy_q, busy_d;
  logic                rd_hit_q, rd_hit_d;
  logic                dr_q, dr_d;
  logic [11:0]         snap_x_q, snap_y_q, snap_z_q, snap_x_d, snap_y_d, snap_z_d;
  logic                pend_vld_q, pend_vld_d;
  logic [11:0]         pend_x_q, pend_y_q, pend_z_q, pend_x_d, pend_y_d, pend_z_d;
  logic [7:0]          cfg_q [32];
  logic [7:0]          cfg_d [32];

  // Only a rise that closes a transaction we saw open counts; stray rises after reset do not.
  assign xfer_end = ncs_rise & busy_q;

  // Register read mux: the address of the byte about to be loaded into the shift register.
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_in_sample;
  logic              addr_is_cfg;
  assign rd_addr      = (state_q == StAddr) ? byte_q[ADDR_W-1:0] : addr_q + ADDR_W'(1);
  assign rd_in_sample = (rd_addr >= ADDR_W'('h08)) && (rd_addr <= ADDR_W'('h13));
  assign addr_is_cfg  = (addr_q[ADDR_W-1:5] == (ADDR_W-5)'(1));

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_W'('h00): rd_data = 8'hAD;
      ADDR_W'('h01): rd_data = 8'h1D;
      ADDR_W'('h02): rd_data = 8'hF2;
      ADDR_W'('h03): rd_data = 8'h01;
      ADDR_W'('h08): rd_data = snap_x_q[11:4];
      ADDR_W'('h09): rd_data = snap_y_q[11:4];
      ADDR_W'('h0A): rd_data = snap_z_q[11:4];
      ADDR_W'('h0B): rd_data = {7'b0, dr_q};
      ADDR_W'('h0E): rd_data = snap_x_q[7:0];
      ADDR_W'('h0F): rd_data = {{4{snap_x_q[11]}}, snap_x_q[11:8]};
      ADDR_W'('h10): rd_data = snap_y_q[7:0];
      ADDR_W'('h11): rd_data = {{4{snap_y_q[11]}}, snap_y_q[11:8]};
      ADDR_W'('h12): rd_data = snap_z_q[7:0];
      ADDR_W'('h13): rd_data = {{4{snap_z_q[11]}}, snap_z_q[11:8]};
      default: begin
        if (rd_addr[ADDR_W-1:5] == (ADDR_W-5)'(1)) rd_data = cfg_q[rd_addr[4:0]];
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    busy_d     = busy_q;
    rd_hit_d   = rd_hit_q;
    cfg_d      = cfg_q;
    if (ncs_fall) begin
      state_d   = StCmd;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
      rd_hit_d  = 1'b0;
      miso_d    = 1'b0;
      tx_d      = 8'h00;
    end else if (ncs_rise) begin
      // Any partial byte is dropped: the bit counter restarts at the next nCS fall.
      state_d   = StIdle;
      busy_d    = 1'b0;
      miso_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (state_q != StIdle) begin
      if (sclk_rise) begin
        rx_d      = {rx_q[5:0], mosi_bit};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_vld_d = 1'b1;
          byte_d     = {rx_q, mosi_bit};
        end
      end
      if (sclk_fall) begin
        if (state_q == StData && is_read_q) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
      if (byte_vld_q) begin
        case (state_q)
          StCmd: begin
            if (byte_q == CmdWrite) begin
              is_read_d = 1'b0;
              state_d   = StAddr;
            end else if (byte_q == CmdRead) begin
              is_read_d = 1'b1;
              state_d   = StAddr;
            end else begin
              state_d = StIgnore;
            end
          end
          StAddr: begin
            addr_d  = byte_q[ADDR_W-1:0];
            state_d = StData;
            if (is_read_q) begin
              tx_d     = rd_data;
              rd_hit_d = rd_hit_q | rd_in_sample;
            end
          end
          StData: begin
            addr_d = addr_q + ADDR_W'(1);
            if (is_read_q) begin
              tx_d     = rd_data;
              rd_hit_d = rd_hit_q | rd_in_sample;
            end else if (addr_is_cfg) begin
              cfg_d[addr_q[4:0]] = byte_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sample capture: direct when idle, pended while busy and committed as the transaction ends.
  always_comb begin
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    snap_z_d   = snap_z_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_z_d   = pend_z_q;
    pend_vld_d = pend_vld_q;
    dr_d       = dr_q;
    if (xfer_end) begin
      pend_vld_d = 1'b0;
      if (sample_valid) begin
        snap_x_d = sample_x;
        snap_y_d = sample_y;
        snap_z_d = sample_z;
        dr_d     = 1'b1;
      end else if (pend_vld_q) begin
        snap_x_d = pend_x_q;
        snap_y_d = pend_y_q;
        snap_z_d = pend_z_q;
        dr_d     = 1'b1;
      end else if (rd_hit_q) begin
        dr_d = 1'b0;
      end
    end else if (sample_valid) begin
      if (busy_q) begin
        pend_x_d   = sample_x;
        pend_y_d   = sample_y;
        pend_z_d   = sample_z;
        pend_vld_d = 1'b1;
      end else begin
        snap_x_d = sample_x;
        snap_y_d = sample_y;
        snap_z_d = sample_z;
        dr_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 7'd0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_hit_q   <= 1'b0;
      dr_q       <= 1'b0;
      snap_x_q   <= 12'd0;
      snap_y_q   <= 12'd0;
      snap_z_q   <= 12'd0;
      pend_vld_q <= 1'b0;
      pend_x_q   <= 12'd0;
      pend_y_q   <= 12'd0;
      pend_z_q   <= 12'd0;
      cfg_q      <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      rd_hit_q   <= rd_hit_d;
      dr_q       <= dr_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_z_q   <= snap_z_d;
      pend_vld_q <= pend_vld_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_z_q   <= pend_z_d;
      cfg_q      <= cfg_d;
    end
  end

  assign miso_o  = miso_q;
  assign miso_oe = busy_q;
  assign busy    = busy_q;

`ifdef SPI_ACCEL_INT_EN
  // Bit0 of 0x2A/0x2B enables the pin, bit7 inverts its polarity.
  logic int1_q, int2_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      int1_q <= 1'b0;
      int2_q <= 1'b0;
    end else begin
      int1_q <= (dr_q & cfg_q[10][0]) ^ cfg_q[10][7];
      int2_q <= (dr_q & cfg_q[11][0]) ^ cfg_q[11][7];
    end
  end
  assign int1_o = int1_q;
  assign int2_o = int2_q;
`else
  assign int1_o = 1'b0;
  assign int2_o = 1'b0;
`endif

endmodule
